sudoku_prop_engine: RTL and testbench

- Parametrised, sequential constraint-propagation engine for generalised sudoku grids of size N×N, where N = BOX*BOX.
- Sits in front of the existing solver's search logic and replaces its wide flat grid bus with a streamed load/unload interface.
- Runs repeated singleton-elimination passes over a register-held candidate grid.
- Reports the same solver status set: unsolved count, done, error, changed, timeout, and the best branch cell.

---
 rtl/sudoku_prop_engine.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_sudoku_prop_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_prop_engine.sv
// -----------------------------------------------------------------------------
// sudoku_prop_engine
//
// Streamed constraint-propagation front end for an N x N generalised sudoku
// (N = BOX*BOX). A grid of candidate bitmasks is loaded one cell per beat,
// refined by repeated singleton-elimination sweeps, scanned for status, and
// streamed back out. The status set matches the one the search logic expects.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   clr                synchronous abort: back to IDLE with status cleared
//   start              begin a load (only honoured in IDLE)
//   inValid/inReady    load handshake; inMask is the candidate mask of the
//                      current cell, row-major, bit d means digit d+1 possible
//   outValid/outReady  unload handshake; outMask is the current cell's mask,
//                      outLast marks cell CELLS-1
//   busy               engine is not in IDLE
//   unsolvedCells      cells whose popcount is not 1 after the last scan
//   timeOut            stopped because MAX_PASSES sweeps were used up
//   allDone            every cell is a singleton and none is empty
//   anyChanged         the last sweep cleared at least one candidate bit
//   anyError           some cell has no candidates left
//   minIdx/minPoss     lowest-index cell with the smallest popcount >= 2,
//                      and that popcount (0 when no such cell exists)
// -----------------------------------------------------------------------------
module sudoku_prop_engine #(
  parameter  int BOX        = 3,
  parameter  int MAX_PASSES = 16,
  localparam int N          = BOX * BOX,
  localparam int CELLS      = N * N,
  localparam int IDX_W      = $clog2(CELLS),
  localparam int CNT_W      = $clog2(CELLS + 1),
  localparam int POSS_W     = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic              inValid,
  output logic              inReady,
  input  logic [N-1:0]      inMask,
  output logic              outValid,
  input  logic              outReady,
  output logic [N-1:0]      outMask,
  output logic              outLast,
  output logic              busy,
  output logic [CNT_W-1:0]  unsolvedCells,
  output logic              timeOut,
  output logic              allDone,
  output logic              anyChanged,
  output logic              anyError,
  output logic [IDX_W-1:0]  minIdx,
  output logic [POSS_W-1:0] minPoss
);

  localparam int PASS_W = $clog2(MAX_PASSES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SWEEP  = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [POSS_W-1:0] POSS_ONE = POSS_W'(1);
  localparam logic [POSS_W-1:0] POSS_TWO = POSS_W'(2);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(MAX_PASSES);

  // Number of candidate digits left in a cell mask.
  function automatic logic [POSS_W-1:0] popCount(input logic [N-1:0] m);
    logic [POSS_W-1:0] c;
    c = '0;
    for (int b = 0; b < N; b++) begin
      c = c + POSS_W'(m[b]);
    end
    return c;
  endfunction

  function automatic int cellRow(input int c);
    return c / N;
  endfunction

  function automatic int cellCol(input int c);
    return c % N;
  endfunction

  function automatic int cellBox(input int c);
    return ((c / N) / BOX) * BOX + (c % N) / BOX;
  endfunction

  logic [2:0]        state;
  logic [IDX_W-1:0]  ptr;
  logic [PASS_W-1:0] passCnt;
  logic              sweepChanged;
  logic [N-1:0]      grid [CELLS];

  logic [CNT_W-1:0]  accUnsolved;
  logic              accError;
  logic [IDX_W-1:0]  accMinIdx;
  logic [POSS_W-1:0] accMinPoss;

  logic [N-1:0]      curMask;
  logic [POSS_W-1:0] curPoss;
  int                pRow;
  int                pCol;
  int                pBox;
  logic [N-1:0]      sweepGrid [CELLS];
  logic              sweepHit;

  logic [CNT_W-1:0]  scanUnsolved;
  logic              scanError;
  logic [IDX_W-1:0]  scanMinIdx;
  logic [POSS_W-1:0] scanMinPoss;
  logic              scanDone;
  logic [PASS_W-1:0] passNext;

  // Handshake flags and the unload beat come straight from registered state.
  assign inReady  = (state == S_LOAD);
  assign outValid = (state == S_UNLOAD);
  assign busy     = (state != S_IDLE);
  assign outMask  = outValid ? grid[ptr] : '0;
  assign outLast  = outValid && (ptr == LAST_IDX);

  // Elimination for the pivot cell: a singleton pivot strips its digit from
  // every row/column/box peer; sweepHit flags whether any bit actually fell.
  always_comb begin
    curMask  = grid[ptr];
    curPoss  = popCount(curMask);
    pRow     = cellRow(int'(ptr));
    pCol     = cellCol(int'(ptr));
    pBox     = cellBox(int'(ptr));
    sweepHit = 1'b0;
    for (int q = 0; q < CELLS; q++) begin
      if ((curPoss == POSS_ONE) && (q != int'(ptr)) &&
          ((cellRow(q) == pRow) || (cellCol(q) == pCol) || (cellBox(q) == pBox))) begin
        sweepGrid[q] = grid[q] & ~curMask;
        sweepHit     = sweepHit | ((grid[q] & curMask) != '0);
      end else begin
        sweepGrid[q] = grid[q];
      end
    end
  end

  // Status accumulation including the cell currently under the scan pointer.
  always_comb begin
    if (curPoss != POSS_ONE) begin
      scanUnsolved = accUnsolved + CNT_ONE;
    end else begin
      scanUnsolved = accUnsolved;
    end
    if (curMask == '0) begin
      scanError = 1'b1;
    end else begin
      scanError = accError;
    end
    // Strict less-than keeps the lowest index on ties; 0 means "none yet".
    if ((curPoss >= POSS_TWO) && ((accMinPoss == '0) || (curPoss < accMinPoss))) begin
      scanMinIdx  = ptr;
      scanMinPoss = curPoss;
    end else begin
      scanMinIdx  = accMinIdx;
      scanMinPoss = accMinPoss;
    end
    scanDone = (scanUnsolved == '0) && !scanError;
    passNext = passCnt + PASS_ONE;
  end

  // Control FSM, candidate grid and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      passCnt       <= '0;
      sweepChanged  <= 1'b0;
      accUnsolved   <= '0;
      accError      <= 1'b0;
      accMinIdx     <= '0;
      accMinPoss    <= '0;
      unsolvedCells <= '0;
      timeOut       <= 1'b0;
      allDone       <= 1'b0;
      anyChanged    <= 1'b0;
      anyError      <= 1'b0;
      minIdx        <= '0;
      minPoss       <= '0;
      for (int c = 0; c < CELLS; c++) begin
        grid[c] <= '0;
      end
    end else if (clr) begin
      // Grid contents are left as they are; the next load overwrites them.
      state         <= S_IDLE;
      ptr           <= '0;
      passCnt       <= '0;
      sweepChanged  <= 1'b0;
      accUnsolved   <= '0;
      accError      <= 1'b0;
      accMinIdx     <= '0;
      accMinPoss    <= '0;
      unsolvedCells <= '0;
      timeOut       <= 1'b0;
      allDone       <= 1'b0;
      anyChanged    <= 1'b0;
      anyError      <= 1'b0;
      minIdx        <= '0;
      minPoss       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_LOAD;
            ptr           <= '0;
            passCnt       <= '0;
            unsolvedCells <= '0;
            timeOut       <= 1'b0;
            allDone       <= 1'b0;
            anyChanged    <= 1'b0;
            anyError      <= 1'b0;
            minIdx        <= '0;
            minPoss       <= '0;
          end
        end
        S_LOAD: begin
          if (inValid) begin
            grid[ptr] <= inMask;
            if (ptr == LAST_IDX) begin
              state        <= S_SWEEP;
              ptr          <= '0;
              sweepChanged <= 1'b0;
            end else begin
              ptr <= ptr + IDX_ONE;
            end
          end
        end
        S_SWEEP: begin
          for (int q = 0; q < CELLS; q++) begin
            grid[q] <= sweepGrid[q];
          end
          if (sweepHit) begin
            sweepChanged <= 1'b1;
          end
          if (ptr == LAST_IDX) begin
            state       <= S_SCAN;
            ptr         <= '0;
            accUnsolved <= '0;
            accError    <= 1'b0;
            accMinIdx   <= '0;
            accMinPoss  <= '0;
          end else begin
            ptr <= ptr + IDX_ONE;
          end
        end
        S_SCAN: begin
          accUnsolved <= scanUnsolved;
          accError    <= scanError;
          accMinIdx   <= scanMinIdx;
          accMinPoss  <= scanMinPoss;
          if (ptr == LAST_IDX) begin
            ptr           <= '0;
            passCnt       <= passNext;
            unsolvedCells <= scanUnsolved;
            anyError      <= scanError;
            anyChanged    <= sweepChanged;
            minIdx        <= scanMinIdx;
            minPoss       <= scanMinPoss;
            allDone       <= scanDone;
            // Error, solved and stalled all outrank the pass budget.
            if (scanError || scanDone || !sweepChanged) begin
              state <= S_UNLOAD;
            end else if (passNext == PASS_MAX) begin
              state   <= S_UNLOAD;
              timeOut <= 1'b1;
            end else begin
              state        <= S_SWEEP;
              sweepChanged <= 1'b0;
            end
          end else begin
            ptr <= ptr + IDX_ONE;
          end
        end
        S_UNLOAD: begin
          if (outReady) begin
            if (ptr == LAST_IDX) begin
              state <= S_IDLE;
              ptr   <= '0;
            end else begin
              ptr <= ptr + IDX_ONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_prop_engine.sv
// -----------------------------------------------------------------------------
// Bench for sudoku_prop_engine at BOX=2 (4x4 grid, 16 cells, 4-bit masks).
// dutA uses the default pass budget; dutB has MAX_PASSES=1 for the timeout
// case. Both share every input except start, so only one is active at a time.
// Grids are packed with cell i in bits [4*i +: 4].
// -----------------------------------------------------------------------------
module tb_sudoku_prop_engine;

  typedef struct packed {
    logic [4:0] unsolved;
    logic       timeOut;
    logic       allDone;
    logic       anyChanged;
    logic       anyError;
    logic [3:0] minIdx;
    logic [2:0] minPoss;
  } status_t;

  typedef struct {
    string       name;
    logic [63:0] grid;
    int          cycles;
    status_t     st;
    logic [63:0] expGrid;
  } vec_t;

  // Rows 1234 / 3412 / 2143 / 4321 as one-hot masks.
  localparam logic [63:0] SOLVED    = 64'h1248_4812_2184_8421;
  // Cells 0, 1 and 8 blank: cell 0 only resolves once cell 1 propagates.
  localparam logic [63:0] TWO_PASS  = 64'h1248_481F_2184_84FF;
  localparam logic [63:0] B_RESULT  = 64'h1248_4812_2184_8423;

  logic       clk = 1'b0;
  logic       rst, clr, startA, startB, inValid, outReady;
  logic [3:0] inMask;

  logic       inReadyA, outValidA, outLastA, busyA, timeOutA, allDoneA, anyChangedA, anyErrorA;
  logic [3:0] outMaskA, minIdxA;
  logic [4:0] unsolvedA;
  logic [2:0] minPossA;
  logic       inReadyB, outValidB, outLastB, busyB, timeOutB, allDoneB, anyChangedB, anyErrorB;
  logic [3:0] outMaskB, minIdxB;
  logic [4:0] unsolvedB;
  logic [2:0] minPossB;

  status_t stA, stB;
  assign stA = {unsolvedA, timeOutA, allDoneA, anyChangedA, anyErrorA, minIdxA, minPossA};
  assign stB = {unsolvedB, timeOutB, allDoneB, anyChangedB, anyErrorB, minIdxB, minPossB};

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  sudoku_prop_engine #(.BOX(2), .MAX_PASSES(16)) dutA (
    .clk(clk), .rst(rst), .clr(clr), .start(startA),
    .inValid(inValid), .inReady(inReadyA), .inMask(inMask),
    .outValid(outValidA), .outReady(outReady), .outMask(outMaskA), .outLast(outLastA),
    .busy(busyA), .unsolvedCells(unsolvedA), .timeOut(timeOutA), .allDone(allDoneA),
    .anyChanged(anyChangedA), .anyError(anyErrorA), .minIdx(minIdxA), .minPoss(minPossA)
  );

  sudoku_prop_engine #(.BOX(2), .MAX_PASSES(1)) dutB (
    .clk(clk), .rst(rst), .clr(clr), .start(startB),
    .inValid(inValid), .inReady(inReadyB), .inMask(inMask),
    .outValid(outValidB), .outReady(outReady), .outMask(outMaskB), .outLast(outLastB),
    .busy(busyB), .unsolvedCells(unsolvedB), .timeOut(timeOutB), .allDone(allDoneB),
    .anyChanged(anyChangedB), .anyError(anyErrorB), .minIdx(minIdxB), .minPoss(minPossB)
  );

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  function automatic status_t mkSt(input int u, input bit to, input bit dn, input bit ch,
                                   input bit er, input int idx, input int poss);
    status_t s;
    s.unsolved   = 5'(u);
    s.timeOut    = to;
    s.allDone    = dn;
    s.anyChanged = ch;
    s.anyError   = er;
    s.minIdx     = 4'(idx);
    s.minPoss    = 3'(poss);
    return s;
  endfunction

  function automatic vec_t mkVec(input string nm, input logic [63:0] g, input int cyc,
                                 input status_t s, input logic [63:0] eg);
    vec_t v;
    v.name    = nm;
    v.grid    = g;
    v.cycles  = cyc;
    v.st      = s;
    v.expGrid = eg;
    return v;
  endfunction

  // Pulse start for one engine, then stream all 16 cells back to back.
  task automatic loadGrid(input logic [63:0] g, input bit toB);
    @(negedge clk);
    if (toB) startB = 1'b1; else startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    for (int i = 0; i < 16; i++) begin
      inValid = 1'b1;
      inMask  = g[4*i +: 4];
      @(negedge clk);
    end
    inValid = 1'b0;
  endtask

  task automatic runVec(input vec_t v);
    int          n;
    logic [63:0] g;
    loadGrid(v.grid, 1'b0);
    n = 0;
    while (!outValidA && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({v.name, "/latency"}, 64'(n), 64'(v.cycles));
    check({v.name, "/status"}, 64'(stA), 64'(v.st));
    g = v.expGrid;
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s/beat%0d", v.name, i), 64'({outValidA, outLastA, outMaskA}),
            64'({1'b1, (i == 15), g[4*i +: 4]}));
      @(negedge clk);
    end
    outReady = 1'b0;
    check({v.name, "/idle"}, 64'(busyA), 64'd0);
    check({v.name, "/hold"}, 64'(stA), 64'(v.st));
  endtask

  vec_t        vecs[5];
  int          n, beat, stalls, guard;
  logic [63:0] g;

  initial begin
    rst = 1'b0; clr = 1'b0; startA = 1'b0; startB = 1'b0;
    inValid = 1'b0; inMask = 4'h0; outReady = 1'b0;

    vecs[0] = mkVec("solved",   SOLVED,                 32, mkSt(0,  0, 1, 0, 0, 0, 0), SOLVED);
    vecs[1] = mkVec("oneBlank", 64'h1248_4812_21F4_8421, 32, mkSt(0,  0, 1, 1, 0, 0, 0), SOLVED);
    vecs[2] = mkVec("conflict", 64'hFFFF_FFFF_FFFF_FF11, 32, mkSt(15, 0, 0, 1, 1, 2, 3),
                    64'hFFFE_FFFE_FFEE_EE01);
    vecs[3] = mkVec("allOpen",  64'hFFFF_FFFF_FFFF_FFFF, 32, mkSt(16, 0, 0, 0, 0, 0, 4),
                    64'hFFFF_FFFF_FFFF_FFFF);
    vecs[4] = mkVec("twoPass",  TWO_PASS,               64, mkSt(0,  0, 1, 1, 0, 0, 0), SOLVED);

    repeat (3) @(negedge clk);
    check("resetState", 64'({busyA, inReadyA, outValidA, outLastA, outMaskA, stA}), 64'd0);
    rst = 1'b1;

    // Asynchronous reset in the middle of a sweep.
    loadGrid(SOLVED, 1'b0);
    repeat (5) @(negedge clk);
    check("sweepBusy", 64'(busyA), 64'd1);
    rst = 1'b0;
    #1;
    check("rstAsync", 64'({busyA, inReadyA, outValidA, outLastA, outMaskA, stA}), 64'd0);
    @(negedge clk);
    check("rstEdge", 64'({busyA, inReadyA, outValidA, outLastA, outMaskA, stA}), 64'd0);
    rst = 1'b1;

    // Clear part-way through a load.
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    g = SOLVED;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inMask  = g[4*i +: 4];
      @(negedge clk);
    end
    check("loadReady", 64'(inReadyA), 64'd1);
    inValid = 1'b0;
    clr     = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clrIdle", 64'({busyA, inReadyA}), 64'd0);

    foreach (vecs[k]) runVec(vecs[k]);

    // Status held in IDLE is wiped by clr.
    check("heldBeforeClr", 64'(stA), 64'(vecs[4].st));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clrStatus", 64'(stA), 64'd0);

    // Pass budget of one on a grid that needs two; start pulsed mid-sweep.
    loadGrid(TWO_PASS, 1'b1);
    n = 0;
    while (!outValidB && n < 300) begin
      startB = (n == 3);
      @(negedge clk);
      n++;
    end
    startB = 1'b0;
    check("B/latency", 64'(n), 64'd32);
    check("B/status", 64'(stB), 64'(mkSt(1, 1, 0, 1, 0, 0, 2)));

    // Unload with outReady held low for 5 cycles at beat 7.
    g      = B_RESULT;
    beat   = 0;
    stalls = 0;
    guard  = 0;
    while (beat < 16 && guard < 100) begin
      guard++;
      if (beat == 7 && stalls < 5) begin
        outReady = 1'b0;
        check($sformatf("B/stall%0d", stalls), 64'({outValidB, outLastB, outMaskB}),
              64'({1'b1, 1'b0, g[28 +: 4]}));
        stalls++;
      end else begin
        outReady = 1'b1;
        check($sformatf("B/beat%0d", beat), 64'({outValidB, outLastB, outMaskB}),
              64'({1'b1, (beat == 15), g[4*beat +: 4]}));
        beat++;
      end
      @(negedge clk);
    end
    outReady = 1'b0;
    check("B/beats", 64'(beat), 64'd16);
    check("B/idle", 64'(busyB), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timeout");
  end

endmodule
